// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache storage array:
// default geometry, width helpers, address field extraction, sweep FSM states.
package cache_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  // Index width for a count of items, never below one bit.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Tag width left over once the set, word and byte fields are removed.
  function automatic int tag_bits(input int addr_bits, input int set_bits,
                                  input int line_words_width, input int word_bytes_width);
    return addr_bits - set_bits - line_words_width - word_bytes_width;
  endfunction

  // Default geometry.
  localparam int CACHE_ADDR_BITS        = 32;
  localparam int CACHE_WORD_BITS        = 32;
  localparam int CACHE_WORD_BYTES_WIDTH = 2;
  localparam int CACHE_LINE_WORDS_WIDTH = 2;
  localparam int CACHE_SET_BITS         = 4;
  localparam int CACHE_WAYS             = 2;
  localparam int CACHE_TAG_BITS   = tag_bits(CACHE_ADDR_BITS, CACHE_SET_BITS,
                                             CACHE_LINE_WORDS_WIDTH, CACHE_WORD_BYTES_WIDTH);
  localparam int CACHE_WAY_BITS   = way_bits(CACHE_WAYS);
  localparam int CACHE_SETS       = 1 << CACHE_SET_BITS;
  localparam int CACHE_LINE_WORDS = 1 << CACHE_LINE_WORDS_WIDTH;

  // Pull a width-bit field starting at bit lsb out of an address.
  function automatic logic [63:0] addr_field(input logic [63:0] a, input int lsb, input int width);
    return (a >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_assoc_if.sv
// Request/response bundle between the memory stage / cache controller and
// the cache storage array.
interface cache_assoc_if
  import cache_pkg::*;
#(
  parameter int ADDR_BITS = CACHE_ADDR_BITS,
  parameter int WORD_BITS = CACHE_WORD_BITS,
  parameter int WAY_BITS  = CACHE_WAY_BITS,
  parameter int TAG_BITS  = CACHE_TAG_BITS
);
  logic [ADDR_BITS-1:0] addr;
  logic [WAY_BITS-1:0]  way;
  logic                 store;
  logic                 edit;
  logic                 invalid;
  logic                 touch;
  logic                 inv_all;
  logic [WORD_BITS-1:0] din;
  logic                 hit;
  logic [WAY_BITS-1:0]  hit_way;
  logic [WORD_BITS-1:0] dout;
  logic [WORD_BITS-1:0] way_dout;
  logic [WAY_BITS-1:0]  victim_way;
  logic                 victim_valid;
  logic                 victim_dirty;
  logic [TAG_BITS-1:0]  victim_tag;
  logic                 busy;
  logic                 done;

  modport master (
    output addr, way, store, edit, invalid, touch, inv_all, din,
    input  hit, hit_way, dout, way_dout, victim_way, victim_valid,
           victim_dirty, victim_tag, busy, done
  );

  modport slave (
    input  addr, way, store, edit, invalid, touch, inv_all, din,
    output hit, hit_way, dout, way_dout, victim_way, victim_valid,
           victim_dirty, victim_tag, busy, done
  );
endinterface

// File: rtl/cache_lru.sv
// True-LRU logic for one set: age update on touch and victim selection.
// Ages form a permutation of 0..WAYS-1; age 0 is MRU, WAYS-1 is LRU.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS     = CACHE_WAYS,
  parameter int AGE_BITS = CACHE_WAY_BITS,
  parameter int WAY_BITS = CACHE_WAY_BITS
) (
  input  logic [WAYS-1:0][AGE_BITS-1:0] ages,
  input  logic [WAYS-1:0]               valid,
  input  logic                          touch,
  input  logic [WAY_BITS-1:0]           way,
  output logic [WAYS-1:0][AGE_BITS-1:0] ages_nxt,
  output logic [WAY_BITS-1:0]           victim_way
);
  logic [AGE_BITS-1:0] way_age;
  logic                found;

  assign way_age = ages[way];

  // Touched way becomes MRU; every younger way ages by one.
  always_comb begin
    ages_nxt = ages;
    if (touch) begin
      for (int i = 0; i < WAYS; i++)
        if (ages[i] < way_age) ages_nxt[i] = ages[i] + 1'b1;
      ages_nxt[way] = '0;
    end
  end

  // Prefer the lowest empty way, otherwise evict the oldest.
  always_comb begin
    victim_way = '0;
    found      = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!found && !valid[i]) begin
        victim_way = WAY_BITS'(i);
        found      = 1'b1;
      end
    end
    if (!found)
      for (int i = 0; i < WAYS; i++)
        if (ages[i] == AGE_BITS'(WAYS - 1)) victim_way = WAY_BITS'(i);
  end
endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative cache storage: tag/valid/dirty/LRU/data arrays,
// combinational lookup, clocked writes, and a one-set-per-cycle
// invalidate-all sweep.
module cache_assoc
  import cache_pkg::*;
#(
  parameter int ADDR_BITS        = CACHE_ADDR_BITS,
  parameter int WORD_BITS        = CACHE_WORD_BITS,
  parameter int WORD_BYTES_WIDTH = CACHE_WORD_BYTES_WIDTH,
  parameter int LINE_WORDS_WIDTH = CACHE_LINE_WORDS_WIDTH,
  parameter int SET_BITS         = CACHE_SET_BITS,
  parameter int WAYS             = CACHE_WAYS
) (
  input  logic         clk,
  input  logic         rst,
  cache_assoc_if.slave bus
);
  localparam int TAG_BITS   = tag_bits(ADDR_BITS, SET_BITS, LINE_WORDS_WIDTH, WORD_BYTES_WIDTH);
  localparam int WAY_BITS   = way_bits(WAYS);
  localparam int AGE_BITS   = WAY_BITS;
  localparam int SETS       = 1 << SET_BITS;
  localparam int LINE_WORDS = 1 << LINE_WORDS_WIDTH;
  localparam int WORD_LSB   = WORD_BYTES_WIDTH;
  localparam int SET_LSB    = WORD_LSB + LINE_WORDS_WIDTH;
  localparam int TAG_LSB    = SET_LSB + SET_BITS;

  typedef logic [WAYS-1:0][AGE_BITS-1:0] ages_t;

  // Storage
  logic [TAG_BITS-1:0]  tags [SETS][WAYS];
  logic [WORD_BITS-1:0] data [SETS][WAYS][LINE_WORDS];
  logic [SETS-1:0][WAYS-1:0] valid;
  logic [SETS-1:0][WAYS-1:0] dirty;
  ages_t                ages [SETS];

  // Sweep FSM
  sweep_state_e         state;
  logic [SET_BITS-1:0]  cnt;
  logic                 busy_q;
  logic                 done_q;

  // Address fields and lookup
  logic [TAG_BITS-1:0]         tag;
  logic [SET_BITS-1:0]         set;
  logic [LINE_WORDS_WIDTH-1:0] word;
  logic [WAY_BITS-1:0]         way_sel;
  logic [WAYS-1:0]             match;
  logic [WAY_BITS-1:0]         hit_way_raw;
  logic                        hit;
  ages_t                       age_init;
  ages_t                       ages_nxt;
  logic [WAY_BITS-1:0]         victim_way;

  assign tag  = TAG_BITS'(addr_field(64'(bus.addr), TAG_LSB, TAG_BITS));
  assign set  = SET_BITS'(addr_field(64'(bus.addr), SET_LSB, SET_BITS));
  assign word = LINE_WORDS_WIDTH'(addr_field(64'(bus.addr), WORD_LSB, LINE_WORDS_WIDTH));

  // A direct-mapped cache has a single way, so the 1-bit way input is ignored.
  assign way_sel = (WAYS == 1) ? '0 : bus.way;

  // Reset/sweep value of a set's ages: way i gets age i.
  always_comb begin
    age_init = '0;
    for (int i = 0; i < WAYS; i++) age_init[i] = AGE_BITS'(i);
  end

  cache_lru #(
    .WAYS     (WAYS),
    .AGE_BITS (AGE_BITS),
    .WAY_BITS (WAY_BITS)
  ) u_lru (
    .ages       (ages[set]),
    .valid      (valid[set]),
    .touch      (bus.touch & ~busy_q),
    .way        (way_sel),
    .ages_nxt   (ages_nxt),
    .victim_way (victim_way)
  );

  // Tag compare across the addressed set; lowest matching way wins.
  always_comb begin
    match       = '0;
    hit_way_raw = '0;
    for (int i = 0; i < WAYS; i++)
      match[i] = valid[set][i] && (tags[set][i] == tag);
    for (int i = WAYS - 1; i >= 0; i--)
      if (match[i]) hit_way_raw = WAY_BITS'(i);
  end

  assign hit              = (|match) & ~busy_q;
  assign bus.hit          = hit;
  assign bus.hit_way      = hit ? hit_way_raw : '0;
  assign bus.dout         = hit ? data[set][hit_way_raw][word] : '0;
  assign bus.way_dout     = data[set][way_sel][word];
  assign bus.victim_way   = victim_way;
  assign bus.victim_valid = valid[set][victim_way];
  assign bus.victim_dirty = dirty[set][victim_way];
  assign bus.victim_tag   = tags[set][victim_way];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  // Sweep FSM plus valid/dirty/age state; the sweep owns these arrays while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      valid  <= '0;
      dirty  <= '0;
      for (int s = 0; s < SETS; s++) ages[s] <= age_init;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.invalid) begin
            valid[set][way_sel] <= 1'b0;
            dirty[set][way_sel] <= 1'b0;
          end else if (bus.store) begin
            valid[set][way_sel] <= 1'b1;
            dirty[set][way_sel] <= 1'b0;
          end else if (bus.edit) begin
            dirty[set][way_sel] <= 1'b1;
          end
          ages[set] <= ages_nxt;
          if (bus.inv_all) begin
            state  <= SWEEP;
            busy_q <= 1'b1;
            cnt    <= '0;
          end
        end
        SWEEP: begin
          valid[cnt] <= '0;
          dirty[cnt] <= '0;
          ages[cnt]  <= age_init;
          cnt        <= cnt + 1'b1;
          if (&cnt) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!busy_q && !bus.invalid) begin
      if (bus.store || bus.edit) data[set][way_sel][word] <= bus.din;
      if (bus.store) tags[set][way_sel] <= tag;
    end
  end
endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc (WAYS=2, 16 sets, 4-word lines).
module tb_cache_assoc;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  cache_assoc_if #(.ADDR_BITS(32), .WORD_BITS(32), .WAY_BITS(1), .TAG_BITS(24)) bus ();

  cache_assoc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ops();
    bus.store   = 1'b0;
    bus.edit    = 1'b0;
    bus.invalid = 1'b0;
    bus.touch   = 1'b0;
    bus.inv_all = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clr_ops();
    bus.addr = 32'h100;
    bus.way  = 1'b0;
    bus.din  = '0;
    repeat (2) step();
    rst = 1'b1;
    step();
    n_vec++; if (bus.hit !== 1'b0) begin n_err++; $display("FAIL rst_hit: got %0h want 0", bus.hit); end
    n_vec++; if (bus.victim_way !== 1'b0) begin n_err++; $display("FAIL rst_victim_way: got %0h want 0", bus.victim_way); end
    n_vec++; if (bus.victim_valid !== 1'b0) begin n_err++; $display("FAIL rst_victim_valid: got %0h want 0", bus.victim_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0h want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0h want 0", bus.done); end
  endtask

  task automatic test_fill_way0();
    for (int k = 0; k < 4; k++) begin
      bus.addr  = 32'h100 + 32'(4 * k);
      bus.way   = 1'b0;
      bus.store = 1'b1;
      bus.din   = 32'hA0 + 32'(k);
      step();
    end
    clr_ops();
    bus.touch = 1'b1;
    bus.way   = 1'b0;
    step();
    clr_ops();
    bus.addr = 32'h104;
    #1;
    n_vec++; if (bus.hit !== 1'b1) begin n_err++; $display("FAIL fill0_hit: got %0h want 1", bus.hit); end
    n_vec++; if (bus.hit_way !== 1'b0) begin n_err++; $display("FAIL fill0_hit_way: got %0h want 0", bus.hit_way); end
    n_vec++; if (bus.dout !== 32'hA1) begin n_err++; $display("FAIL fill0_dout: got %0h want a1", bus.dout); end
    n_vec++; if (bus.victim_way !== 1'b1) begin n_err++; $display("FAIL fill0_victim: got %0h want 1", bus.victim_way); end
    bus.addr = 32'h10C;
    #1;
    n_vec++; if (bus.dout !== 32'hA3) begin n_err++; $display("FAIL fill0_dout_last: got %0h want a3", bus.dout); end
  endtask

  task automatic test_fill_way1_lru();
    for (int k = 0; k < 4; k++) begin
      bus.addr  = 32'h200 + 32'(4 * k);
      bus.way   = 1'b1;
      bus.store = 1'b1;
      bus.din   = 32'hB0 + 32'(k);
      bus.touch = (k == 3);
      step();
    end
    clr_ops();
    bus.addr = 32'h208;
    #1;
    n_vec++; if (bus.hit_way !== 1'b1) begin n_err++; $display("FAIL fill1_hit_way: got %0h want 1", bus.hit_way); end
    n_vec++; if (bus.dout !== 32'hB2) begin n_err++; $display("FAIL fill1_dout: got %0h want b2", bus.dout); end
    n_vec++; if (bus.victim_way !== 1'b0) begin n_err++; $display("FAIL lru_after_touch1: got %0h want 0", bus.victim_way); end
    bus.touch = 1'b1;
    bus.way   = 1'b0;
    step();
    clr_ops();
    bus.addr = 32'h200;
    #1;
    n_vec++; if (bus.victim_way !== 1'b1) begin n_err++; $display("FAIL lru_after_touch0: got %0h want 1", bus.victim_way); end
    n_vec++; if (bus.victim_tag !== 24'h2) begin n_err++; $display("FAIL lru_victim_tag: got %0h want 2", bus.victim_tag); end
  endtask

  task automatic test_edit_invalid();
    bus.addr = 32'h204;
    bus.way  = 1'b1;
    bus.edit = 1'b1;
    bus.din  = 32'hDEAD;
    step();
    clr_ops();
    bus.addr = 32'h200;
    #1;
    n_vec++; if (bus.victim_dirty !== 1'b1) begin n_err++; $display("FAIL edit_dirty: got %0h want 1", bus.victim_dirty); end
    n_vec++; if (bus.victim_tag !== 24'h2) begin n_err++; $display("FAIL edit_tag: got %0h want 2", bus.victim_tag); end
    bus.addr = 32'h204;
    #1;
    n_vec++; if (bus.way_dout !== 32'hDEAD) begin n_err++; $display("FAIL edit_way_dout: got %0h want dead", bus.way_dout); end
    bus.addr    = 32'h100;
    bus.way     = 1'b0;
    bus.invalid = 1'b1;
    bus.store   = 1'b1;
    bus.din     = 32'h77;
    step();
    clr_ops();
    #1;
    n_vec++; if (bus.hit !== 1'b0) begin n_err++; $display("FAIL inv_over_store_hit: got %0h want 0", bus.hit); end
    n_vec++; if (bus.victim_way !== 1'b0) begin n_err++; $display("FAIL inv_victim_way: got %0h want 0", bus.victim_way); end
    n_vec++; if (bus.victim_dirty !== 1'b0) begin n_err++; $display("FAIL inv_victim_dirty: got %0h want 0", bus.victim_dirty); end
    bus.addr = 32'h200;
    #1;
    n_vec++; if (bus.hit !== 1'b1) begin n_err++; $display("FAIL inv_other_way_hit: got %0h want 1", bus.hit); end
  endtask

  task automatic test_sweep();
    int n;
    bus.addr    = 32'h200;
    bus.inv_all = 1'b1;
    step();
    clr_ops();
    #1;
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL sweep_busy_start: got %0h want 1", bus.busy); end
    n_vec++; if (bus.hit !== 1'b0) begin n_err++; $display("FAIL sweep_hit_forced: got %0h want 0", bus.hit); end
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      bus.store = (n == 5);
      bus.addr  = 32'h300;
      bus.way   = 1'b0;
      bus.din   = 32'h55;
      step();
    end
    clr_ops();
    n_vec++; if (n !== 16) begin n_err++; $display("FAIL sweep_busy_cycles: got %0d want 16", n); end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL sweep_done: got %0h want 1", bus.done); end
    step();
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL sweep_done_pulse: got %0h want 0", bus.done); end
    bus.addr = 32'h300;
    #1;
    n_vec++; if (bus.hit !== 1'b0) begin n_err++; $display("FAIL sweep_store_dropped: got %0h want 0", bus.hit); end
    bus.addr = 32'h200;
    #1;
    n_vec++; if (bus.hit !== 1'b0) begin n_err++; $display("FAIL sweep_miss_200: got %0h want 0", bus.hit); end
    n_vec++; if (bus.victim_valid !== 1'b0) begin n_err++; $display("FAIL sweep_victim_valid: got %0h want 0", bus.victim_valid); end
  endtask

  task automatic test_reset_mid_sweep();
    bus.addr  = 32'h080;
    bus.way   = 1'b0;
    bus.store = 1'b1;
    bus.din   = 32'h1;
    step();
    bus.addr  = 32'h180;
    bus.way   = 1'b1;
    bus.din   = 32'h2;
    bus.touch = 1'b1;
    step();
    clr_ops();
    bus.addr = 32'h080;
    #1;
    n_vec++; if (bus.victim_way !== 1'b0) begin n_err++; $display("FAIL pre_rst_victim: got %0h want 0", bus.victim_way); end
    bus.inv_all = 1'b1;
    step();
    clr_ops();
    repeat (4) step();
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %0h want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mid_rst_done: got %0h want 0", bus.done); end
    #1;
    rst = 1'b1;
    step();
    bus.addr = 32'h080;
    #1;
    n_vec++; if (bus.hit !== 1'b0) begin n_err++; $display("FAIL post_rst_hit: got %0h want 0", bus.hit); end
    n_vec++; if (bus.victim_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_victim_valid: got %0h want 0", bus.victim_valid); end
    bus.way   = 1'b0;
    bus.store = 1'b1;
    step();
    bus.addr  = 32'h180;
    bus.way   = 1'b1;
    step();
    clr_ops();
    bus.addr = 32'h080;
    #1;
    n_vec++; if (bus.hit !== 1'b1) begin n_err++; $display("FAIL post_rst_refill_hit: got %0h want 1", bus.hit); end
    n_vec++; if (bus.victim_way !== 1'b1) begin n_err++; $display("FAIL post_rst_ages: got %0h want 1", bus.victim_way); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_fill_way0();
    test_fill_way1_lru();
    test_edit_invalid();
    test_sweep();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_assoc.md
Name: cache_assoc

Overview:
- Parametrised N-way set-associative cache storage array with true-LRU replacement and a multi-cycle invalidate-all sweep. Direct-mapped is the WAYS=1 case.
- Holds tag, valid, dirty, per-set LRU ages and word data.
- Lookup is combinational. Writes, LRU updates and the sweep are clocked.
- Sits between the pipeline memory stage and the cache controller FSM. The controller supplies way selection for fills and write-backs.

Parameters:
- ADDR_BITS, 32, byte address width.
- WORD_BITS, 32, data word width.
- WORD_BYTES_WIDTH, 2, log2 of bytes per word.
- LINE_WORDS_WIDTH, 2, log2 of words per line.
- SET_BITS, 4, log2 of set count.
- WAYS, 2, associativity; power of two, 1..8.
- TAG_BITS, ADDR_BITS-SET_BITS-LINE_WORDS_WIDTH-WORD_BYTES_WIDTH, derived; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  ADDR_BITS  lookup/write address.
- way  in  max(1,log2 WAYS)  target way for store/edit/invalid/touch and for way_dout.
- store  in  1  write din into addr word of way; set valid=1, dirty=0, tag=addr tag.
- edit  in  1  write din into addr word of way; set dirty=1; tag unchanged.
- invalid  in  1  clear valid and dirty of way in addr set.
- touch  in  1  make way MRU in addr set.
- inv_all  in  1  start invalidate-all sweep.
- din  in  WORD_BITS  write data.
- hit  out  1  some valid way in addr set has a matching tag.
- hit_way  out  max(1,log2 WAYS)  matching way; 0 on miss.
- dout  out  WORD_BITS  addr word from hit_way; 0 on miss.
- way_dout  out  WORD_BITS  addr word from way, for write-back.
- victim_way  out  max(1,log2 WAYS)  replacement candidate in addr set.
- victim_valid, victim_dirty  out  1 each  state of victim_way.
- victim_tag  out  TAG_BITS  tag of victim_way.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Address split: tag = top TAG_BITS; set = next SET_BITS; word = next LINE_WORDS_WIDTH; low WORD_BYTES_WIDTH bits are ignored.
- Reset (async assert):
  - all valid and dirty bits = 0.
  - ages[set][i] = i.
  - FSM = IDLE; busy = 0; done = 0.
  - Tag and data arrays are not reset.
- All outputs are combinational from the current state and addr. A write is visible on the cycle after its clock edge.
- Multiple hits cannot occur by construction. If they do, the lowest way wins.
- Write priority in the same cycle, same way: invalid > store > edit.
  - Data is written if store or edit is set and invalid is not.
  - Writes to different words of the same line in consecutive cycles are the normal refill pattern.
- touch is independent of the write ops and may coincide with store or edit.
- LRU, per set, with an age of log2(WAYS) bits per way (1 bit when WAYS=1):
  - On touch(w): every way with age < age[w] increments; age[w] = 0. The ages stay a permutation.
  - victim_way = lowest-index way with valid=0; otherwise the way with age = WAYS-1.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on inv_all. A counter starts at 0.
  - In SWEEP, each cycle clears valid/dirty and resets ages for set[counter], then increments the counter.
  - After set 2^SET_BITS-1: return to IDLE and pulse done for one cycle.
  - busy = 1 for exactly 2^SET_BITS cycles.
  - While busy: store/edit/invalid/touch/inv_all are ignored; hit is forced to 0.
  - Reset asserted mid-sweep returns the FSM to IDLE immediately.

Decomposition:
- Package cache_pkg holds:
  - derived widths: TAG_BITS, WAY_BITS = max(1,log2 WAYS), SETS, LINE_WORDS.
  - address field extraction functions.
  - FSM state enum.
- Sub-module cache_lru (combinational, one set): takes the ages vector, valid vector, touch and way; produces next ages and victim_way. It is instantiated once on the addressed set.

Test Plan (WAYS=2, SET_BITS=4, LINE_WORDS_WIDTH=2, so set = addr[7:4]):
- Reset, then lookup addr=0x100 -> hit=0, victim_way=0, victim_valid=0, busy=0.
- store way0 to 0x100/104/108/10C with din 0xA0..0xA3, then touch way0; read 0x104 -> hit=1, hit_way=0, dout=0xA1, victim_way=1.
- Fill way1 at 0x200 (tag 0x2) and touch way1 -> victim_way=0. Then touch way0 -> victim_way=1 and victim_tag=0x2.
- edit way1 at 0x204 with din=0xDEAD, addr=0x200 -> victim_dirty=1, way_dout(0x204)=0xDEAD, tag still 0x2. Then invalid and store way0 in the same cycle at 0x100 -> hit on 0x100 = 0, victim_way=0, victim_dirty=0.
- Pulse inv_all -> busy=1 for 16 cycles, done=1 on the next cycle. A store issued during busy is dropped, and all lookups miss afterwards.
- Assert rst during cycle 5 of the sweep -> busy=0 and done=0 immediately. After release, all ways are invalid and ages are back to 0/1.
